// File: rtl/oka_pkg.sv
// oka_pkg: shared constants, FSM state encoding and even/odd coefficient split
// helpers for the Karatsuba sequential carry-less multiplier.
//   N  : operand width in coefficients (must be even)
//   H  : sub-multiplier width (N/2)
//   PW : sub-product width (2H-1)
package oka_pkg;

  localparam int N  = 16;
  localparam int H  = N / 2;
  localparam int PW = 2 * H - 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL_EE = 3'd1,
    MUL_OO = 3'd2,
    MUL_MM = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Coefficients 0,2,4,.. of v packed into H bits.
  function automatic logic [H-1:0] even_bits(input logic [N-1:0] v);
    logic [H-1:0] r;
    r = '0;
    for (int i = 0; i < H; i++) r[i] = v[2*i];
    return r;
  endfunction

  // Coefficients 1,3,5,.. of v packed into H bits.
  function automatic logic [H-1:0] odd_bits(input logic [N-1:0] v);
    logic [H-1:0] r;
    r = '0;
    for (int i = 0; i < H; i++) r[i] = v[2*i+1];
    return r;
  endfunction

endpackage

// File: rtl/clmul_hbit.sv
// clmul_hbit: combinational W x W carry-less (GF(2)[x]) multiplier.
//   a_i : W-bit polynomial
//   b_i : W-bit polynomial
//   p_o : 2W-1 bit product, XOR of shifted AND rows
module clmul_hbit #(
  parameter int W = 8
) (
  input  logic [W-1:0]   a_i,
  input  logic [W-1:0]   b_i,
  output logic [2*W-2:0] p_o
);

  logic [W-1:0][2*W-2:0] pp;

  // One partial-product row per coefficient of b, pre-shifted into place.
  for (genvar i = 0; i < W; i++) begin : g_row
    assign pp[i] = {{(W-1){1'b0}}, a_i & {W{b_i[i]}}} << i;
  end

  always_comb begin
    p_o = '0;
    for (int i = 0; i < W; i++) p_o = p_o ^ pp[i];
  end

endmodule

// File: rtl/oka_seq_mul_ctrl.sv
// oka_seq_mul_ctrl: sequential 16x16 carry-less multiplier. One shared HxH
// carry-less multiplier is reused over three cycles for the even/even,
// odd/odd and mixed Karatsuba sub-products, then the result is recombined.
//   clk       : clock
//   rst       : synchronous active-high reset
//   in_valid  / in_ready  : operand handshake (in_ready high only in IDLE)
//   in_a, in_b: N-bit operands, coefficient i at bit i
//   out_valid / out_ready : result handshake, result held while stalled
//   out_p     : 2N-1 bit product
module oka_seq_mul_ctrl
  import oka_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-2:0] out_p
);

  state_e state_q, state_d;

  logic [H-1:0]   ae_q, ao_q, be_q, bo_q;
  logic [PW-1:0]  pee_q, poo_q;
  logic [2*N-2:0] out_p_q, out_p_d;
  logic           out_valid_q;

  logic [H-1:0]   mul_a, mul_b;
  logic [PW-1:0]  mul_p;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;

  // Next state and shared-multiplier operand select.
  always_comb begin
    state_d = state_q;
    mul_a   = ae_q;
    mul_b   = be_q;
    unique case (state_q)
      IDLE:   if (in_valid) state_d = MUL_EE;
      MUL_EE: state_d = MUL_OO;
      MUL_OO: begin
        mul_a   = ao_q;
        mul_b   = bo_q;
        state_d = MUL_MM;
      end
      MUL_MM: begin
        mul_a   = ae_q ^ ao_q;
        mul_b   = be_q ^ bo_q;
        state_d = DONE;
      end
      DONE:   if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  clmul_hbit #(.W(H)) u_clmul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  // Recombine. Pmm is taken live from the multiplier during MUL_MM so the
  // result registers on the same edge that enters DONE.
  // Even coefficients: Pee[k] ^ Poo[k-1]; the extended vectors supply the
  // zero ends, which also makes the top coefficient equal Poo[PW-1].
  // Odd coefficients: Pee ^ Poo ^ Pmm (the Karatsuba middle term).
  logic [PW-1:0] m;
  logic [PW:0]   pee_x, poo_sh;

  always_comb begin
    m       = pee_q ^ poo_q ^ mul_p;
    pee_x   = {1'b0, pee_q};
    poo_sh  = {poo_q, 1'b0};
    out_p_d = '0;
    for (int k = 0; k <= PW; k++) out_p_d[2*k]   = pee_x[k] ^ poo_sh[k];
    for (int k = 0; k <  PW; k++) out_p_d[2*k+1] = m[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ae_q        <= '0;
      ao_q        <= '0;
      be_q        <= '0;
      bo_q        <= '0;
      pee_q       <= '0;
      poo_q       <= '0;
      out_p_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (in_valid) begin
          ae_q <= even_bits(in_a);
          ao_q <= odd_bits(in_a);
          be_q <= even_bits(in_b);
          bo_q <= odd_bits(in_b);
        end
        MUL_EE: pee_q <= mul_p;
        MUL_OO: poo_q <= mul_p;
        MUL_MM: begin
          out_p_q     <= out_p_d;
          out_valid_q <= 1'b1;
        end
        DONE: if (out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_oka_seq_mul_ctrl.sv
// Bench for oka_seq_mul_ctrl: directed cases plus randomized back-to-back
// traffic with random consumer stalls, checked against a plain carry-less
// multiply model and an in-order expected-result queue.
module tb_oka_seq_mul_ctrl;

  localparam int N = 16;
  localparam int PW2 = 2 * N - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_a, in_b;
  logic           out_valid;
  logic           out_ready;
  logic [PW2-1:0] out_p;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  oka_seq_mul_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: schoolbook carry-less product.
  function automatic logic [PW2-1:0] clmul_ref(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [PW2-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (a[i]) r = r ^ (PW2'(b) << i);
    return r;
  endfunction

  // Drive one op from IDLE (all sampling/driving at negedge) and check
  // latency, hold behaviour under stall and return to IDLE.
  // hold=1 keeps in_valid high with (a2,b2) while the op is in flight.
  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [PW2-1:0] exp, input int stall,
                        input bit hold, input logic [N-1:0] a2, input logic [N-1:0] b2);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    if (!in_ready) chk({tag, "_idle_timeout"}, 0, 1);
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    out_ready = (stall == 0);
    @(negedge clk);                       // accept edge passed
    in_valid = hold;
    in_a     = hold ? a2 : N'($urandom);
    in_b     = hold ? b2 : N'($urandom);
    for (int e = 0; e < 3; e++) begin
      chk({tag, "_busy_ready"}, in_ready, 0);
      chk({tag, "_early_valid"}, out_valid, 0);
      @(negedge clk);
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_p"}, out_p, exp);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_p"}, out_p, exp);
      chk({tag, "_hold_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_drop_valid"}, out_valid, 0);
    chk({tag, "_back_idle"}, in_ready, 1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    logic [PW2-1:0] q[$];
    logic [PW2-1:0] last_p, e;
    bit stalled;
    int accepted, done, cyc;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_p", out_p, 0);

    run_op("t1", 16'h0003, 16'h0003, 31'h0000_0005, 0, 0, '0, '0);
    run_op("t2a", 16'h8000, 16'h8000, 31'h4000_0000, 0, 0, '0, '0);
    run_op("t2b", 16'hFFFF, 16'h0001, 31'h0000_FFFF, 0, 0, '0, '0);
    run_op("t3", 16'hFFFF, 16'hFFFF, 31'h5555_5555, 6, 0, '0, '0);

    // Second pair held valid throughout the first op; it must be taken
    // only after the first completes.
    run_op("t4a", 16'h1234, 16'h00F1, clmul_ref(16'h1234, 16'h00F1), 2, 1, 16'hA5A5, 16'h0F0F);
    chk("t4_second_waiting", in_ready, 1);
    run_op("t4b", 16'hA5A5, 16'h0F0F, clmul_ref(16'hA5A5, 16'h0F0F), 0, 0, '0, '0);

    // Reset while in MUL_OO.
    in_valid = 1'b1; in_a = 16'hBEEF; in_b = 16'hCAFE; out_ready = 1'b1;
    @(negedge clk);                       // MUL_EE
    in_valid = 1'b0;
    @(negedge clk);                       // MUL_OO
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_idle", in_ready, 1);
    chk("t5_valid", out_valid, 0);
    chk("t5_p", out_p, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_pulse", out_valid, 0);
    end
    run_op("t5_fresh", 16'h0001, 16'h0001, 31'h0000_0001, 0, 0, '0, '0);

    // Random back-to-back traffic with random stalls.
    accepted = 0; done = 0; cyc = 0; stalled = 0; last_p = '0;
    while ((accepted < 1000 || q.size() != 0) && cyc < 40000) begin
      if (stalled) begin
        chk("rnd_hold_valid", out_valid, 1);
        chk("rnd_hold_p", out_p, last_p);
      end
      ra = N'($urandom); rb = N'($urandom);
      in_valid  = (accepted < 1000) && ($urandom_range(0, 7) != 0);
      in_a      = ra;
      in_b      = rb;
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_valid && in_ready) begin
        q.push_back(clmul_ref(ra, rb));
        accepted++;
      end
      stalled = out_valid && !out_ready;
      last_p  = out_p;
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rnd_spurious", 1, 0);
        else begin
          e = q.pop_front();
          chk("rnd_p", out_p, e);
          done++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("rnd_count", done, 1000);
    chk("rnd_drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
